// File: rtl/tone_sequencer.sv
// Song ROM walker: fetches {note, dur} entries and drives note index, gate and note-on
// to the tone datapath, paced by the tempo strobe, with pause/loop/stop and an articulation gap.
module tone_sequencer #(
  parameter int IDX_BW  = 6,
  parameter int DUR_BW  = 4,
  parameter int ADDR_BW = 6,
  parameter int GAP_BW  = 16,
  parameter int GAP_CYC = 4800
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     strb_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     pause_i,
  input  logic                     loop_i,
  output logic [ADDR_BW-1:0]       rom_addr_o,
  input  logic [IDX_BW+DUR_BW-1:0] rom_data_i,
  output logic [IDX_BW-1:0]        note_index_o,
  output logic                     note_on_o,
  output logic                     gate_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    PLAY  = 3'd2,
    GAP   = 3'd3,
    PAUSE = 3'd4
  } state_t;

  localparam logic [GAP_BW-1:0] GAP_LOAD = GAP_BW'(GAP_CYC);

  state_t              state_q, state_n;
  state_t              saved_q, saved_n;
  logic [DUR_BW-1:0]   dur_q, dur_n;
  logic [GAP_BW-1:0]   gap_q, gap_n;
  logic [ADDR_BW-1:0]  addr_n;
  logic [IDX_BW-1:0]   idx_n;
  logic                note_on_n, gate_n, busy_n, done_n;

  logic [IDX_BW-1:0]   rom_note;
  logic [DUR_BW-1:0]   rom_dur;

  assign rom_note = rom_data_i[IDX_BW+DUR_BW-1:DUR_BW];
  assign rom_dur  = rom_data_i[DUR_BW-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      saved_q      <= IDLE;
      dur_q        <= '0;
      gap_q        <= '0;
      rom_addr_o   <= '0;
      note_index_o <= '0;
      note_on_o    <= 1'b0;
      gate_o       <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_n;
      saved_q      <= saved_n;
      dur_q        <= dur_n;
      gap_q        <= gap_n;
      rom_addr_o   <= addr_n;
      note_index_o <= idx_n;
      note_on_o    <= note_on_n;
      gate_o       <= gate_n;
      busy_o       <= busy_n;
      done_o       <= done_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    saved_n   = saved_q;
    dur_n     = dur_q;
    gap_n     = gap_q;
    addr_n    = rom_addr_o;
    idx_n     = note_index_o;
    gate_n    = gate_o;
    note_on_n = 1'b0;
    done_n    = 1'b0;

    if (stop_i) begin
      state_n = IDLE;
      dur_n   = '0;
      gap_n   = '0;
      addr_n  = '0;
      idx_n   = '0;
      gate_n  = 1'b0;
    end else if (start_i) begin
      state_n = FETCH;
      addr_n  = '0;
      gate_n  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          addr_n = '0;
          idx_n  = '0;
          gate_n = 1'b0;
        end
        FETCH: begin
          if (rom_dur != '0) begin
            state_n   = PLAY;
            idx_n     = rom_note;
            dur_n     = rom_dur;
            gate_n    = (rom_note != '0);
            note_on_n = (rom_note != '0);
          end else if (loop_i && rom_addr_o != '0) begin
            addr_n = '0;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
            addr_n  = '0;
            idx_n   = '0;
            gate_n  = 1'b0;
          end
        end
        PLAY: begin
          if (pause_i) begin
            state_n = PAUSE;
            saved_n = PLAY;
            gate_n  = 1'b0;
          end else if (strb_i) begin
            if (dur_q == DUR_BW'(1)) begin
              gate_n = 1'b0;
              dur_n  = '0;
              if (GAP_CYC != 0) begin
                state_n = GAP;
                gap_n   = GAP_LOAD;
              end else begin
                state_n = FETCH;
                addr_n  = rom_addr_o + ADDR_BW'(1);
              end
            end else begin
              dur_n = dur_q - DUR_BW'(1);
            end
          end
        end
        GAP: begin
          gate_n = 1'b0;
          if (pause_i) begin
            state_n = PAUSE;
            saved_n = GAP;
          end else if (gap_q == GAP_BW'(1)) begin
            state_n = FETCH;
            gap_n   = '0;
            addr_n  = rom_addr_o + ADDR_BW'(1);
          end else begin
            gap_n = gap_q - GAP_BW'(1);
          end
        end
        PAUSE: begin
          gate_n = 1'b0;
          // Resuming a sounding note re-triggers the envelope
          if (!pause_i) begin
            state_n = saved_q;
            if (saved_q == PLAY && note_index_o != '0) begin
              gate_n    = 1'b1;
              note_on_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a small song ROM model and a 4-cycle gap.
module tb_tone_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       strb_i = 1'b0, start_i = 1'b0, stop_i = 1'b0, pause_i = 1'b0, loop_i = 1'b0;
  logic [5:0] rom_addr_o;
  logic [9:0] rom_data_i;
  logic [5:0] note_index_o;
  logic       note_on_o, gate_o, busy_o, done_o;

  logic [9:0] rom [64];
  int n_cmp = 0;
  int n_err = 0;

  assign rom_data_i = rom[rom_addr_o];

  always #5 clk_i = ~clk_i;

  tone_sequencer #(
    .IDX_BW(6), .DUR_BW(4), .ADDR_BW(6), .GAP_BW(16), .GAP_CYC(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .strb_i(strb_i), .start_i(start_i),
    .stop_i(stop_i), .pause_i(pause_i), .loop_i(loop_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .note_index_o(note_index_o), .note_on_o(note_on_o),
    .gate_o(gate_o), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = '0;
    rom[0] = {6'd5, 4'd2};
    rom[1] = {6'd9, 4'd1};
    rom[2] = {6'd0, 4'd0};

    // Reset state
    step(2);
    chk("rst_addr", 32'(rom_addr_o), 0);
    chk("rst_idx", 32'(note_index_o), 0);
    chk("rst_gate", 32'(gate_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_note_on", 32'(note_on_o), 0);
    rst_i = 1'b0;
    step();

    // 1: plain playback
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("t1_fetch_busy", 32'(busy_o), 1);
    chk("t1_fetch_gate", 32'(gate_o), 0);
    step();
    chk("t1_n5_idx", 32'(note_index_o), 5);
    chk("t1_n5_gate", 32'(gate_o), 1);
    chk("t1_n5_on", 32'(note_on_o), 1);
    step();
    chk("t1_n5_on_pulse", 32'(note_on_o), 0);
    strb_i = 1'b1; step(); strb_i = 1'b0;
    chk("t1_n5_tick1_gate", 32'(gate_o), 1);
    step(2);
    strb_i = 1'b1; step(); strb_i = 1'b0;
    chk("t1_gap_gate", 32'(gate_o), 0);
    chk("t1_gap_idx", 32'(note_index_o), 5);
    step(3);
    chk("t1_gap_addr", 32'(rom_addr_o), 0);
    step();
    chk("t1_fetch1_addr", 32'(rom_addr_o), 1);
    step();
    chk("t1_n9_idx", 32'(note_index_o), 9);
    chk("t1_n9_on", 32'(note_on_o), 1);
    strb_i = 1'b1; step(); strb_i = 1'b0;
    chk("t1_n9_end_gate", 32'(gate_o), 0);
    step(4);
    chk("t1_fetch2_addr", 32'(rom_addr_o), 2);
    chk("t1_fetch2_done", 32'(done_o), 0);
    step();
    chk("t1_done", 32'(done_o), 1);
    chk("t1_end_busy", 32'(busy_o), 0);
    chk("t1_end_idx", 32'(note_index_o), 0);
    step();
    chk("t1_done_pulse", 32'(done_o), 0);

    // 2: loop back to address 0
    loop_i = 1'b1;
    start_i = 1'b1; step(); start_i = 1'b0;
    step();
    strb_i = 1'b1; step(2); strb_i = 1'b0;
    step(4);
    step();
    chk("t2_n9_idx", 32'(note_index_o), 9);
    strb_i = 1'b1; step(); strb_i = 1'b0;
    step(4);
    chk("t2_fetch2_addr", 32'(rom_addr_o), 2);
    step();
    chk("t2_loop_addr", 32'(rom_addr_o), 0);
    chk("t2_loop_done", 32'(done_o), 0);
    chk("t2_loop_busy", 32'(busy_o), 1);
    step();
    chk("t2_replay_idx", 32'(note_index_o), 5);
    chk("t2_replay_on", 32'(note_on_o), 1);
    loop_i = 1'b0;

    // 5: stop beats start during PLAY, then start alone restarts
    stop_i = 1'b1; start_i = 1'b1; step(); stop_i = 1'b0; start_i = 1'b0;
    chk("t5_idle_busy", 32'(busy_o), 0);
    chk("t5_idle_idx", 32'(note_index_o), 0);
    chk("t5_idle_gate", 32'(gate_o), 0);
    chk("t5_no_done", 32'(done_o), 0);
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("t5_restart_addr", 32'(rom_addr_o), 0);
    step();
    chk("t5_restart_idx", 32'(note_index_o), 5);

    // 4: pause with a coincident tick loses that tick
    pause_i = 1'b1; strb_i = 1'b1; step();
    chk("t4_pause_gate", 32'(gate_o), 0);
    chk("t4_pause_busy", 32'(busy_o), 1);
    step();
    strb_i = 1'b0; pause_i = 1'b0; step();
    chk("t4_resume_gate", 32'(gate_o), 1);
    chk("t4_resume_on", 32'(note_on_o), 1);
    strb_i = 1'b1; step(); strb_i = 1'b0;
    chk("t4_tick1_gate", 32'(gate_o), 1);
    strb_i = 1'b1; step(); strb_i = 1'b0;
    chk("t4_tick2_gate", 32'(gate_o), 0);
    stop_i = 1'b1; step(); stop_i = 1'b0;

    // 3: rest then sounding note
    rom[0] = {6'd0, 4'd3};
    rom[1] = {6'd7, 4'd1};
    rom[2] = {6'd0, 4'd0};
    start_i = 1'b1; step(); start_i = 1'b0;
    step();
    chk("t3_rest_gate", 32'(gate_o), 0);
    chk("t3_rest_on", 32'(note_on_o), 0);
    chk("t3_rest_busy", 32'(busy_o), 1);
    strb_i = 1'b1; step(2); strb_i = 1'b0;
    chk("t3_rest_addr", 32'(rom_addr_o), 0);
    strb_i = 1'b1; step(); strb_i = 1'b0;
    step(4);
    chk("t3_fetch1_addr", 32'(rom_addr_o), 1);
    step();
    chk("t3_n7_idx", 32'(note_index_o), 7);
    chk("t3_n7_on", 32'(note_on_o), 1);
    chk("t3_n7_gate", 32'(gate_o), 1);

    // 6: async reset mid-gap, then empty song
    strb_i = 1'b1; step(); strb_i = 1'b0;
    step();
    #2 rst_i = 1'b1;
    #1;
    chk("t6_arst_idx", 32'(note_index_o), 0);
    chk("t6_arst_busy", 32'(busy_o), 0);
    chk("t6_arst_addr", 32'(rom_addr_o), 0);
    #1 rst_i = 1'b0;
    rom[0] = '0;
    step();
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("t6_empty_fetch_done", 32'(done_o), 0);
    step();
    chk("t6_empty_done", 32'(done_o), 1);
    chk("t6_empty_busy", 32'(busy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
